awg_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the AWG waveform generators. It drives the generator's `en`, `state_freq`, `state_amp` and `state_phase` inputs, stepping the frequency word from a start value to a stop value with a programmable dwell per step. It supports single, repeat and up-down sweeps. Amplitude and phase updates are deferred to step boundaries so the generator never sees a mid-dwell parameter change.

---
 rtl/awg_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_awg_sweep_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_sweep_ctrl.sv
// Frequency-sweep sequencer for the AWG generators: steps state_freq from f_start
// towards f_stop with a programmable dwell, in single, repeat or up-down mode.
module awg_sweep_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [13:0] f_start,
  input  logic [13:0] f_stop,
  input  logic [13:0] f_step,
  input  logic [15:0] dwell,
  input  logic [7:0]  amp_in,
  input  logic [7:0]  phase_in,
  output logic        en,
  output logic [13:0] state_freq,
  output logic [7:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;

  logic [1:0]  mode_q, mode_d;
  logic [13:0] f_start_q, f_start_d;
  logic [13:0] f_stop_q, f_stop_d;
  logic [13:0] f_step_q, f_step_d;
  logic [15:0] dwell_q, dwell_d;

  logic        en_q, en_d;
  logic [13:0] state_freq_q, state_freq_d;
  logic [7:0]  state_amp_q, state_amp_d;
  logic [7:0]  state_phase_q, state_phase_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wrap_q, wrap_d;

  logic [15:0] dwell_last;
  logic        boundary;
  logic [14:0] up_sum;
  logic        up_ok;
  logic [13:0] dn_diff;
  logic        dn_ok;

  // The up sum is one bit wider so a step past 16383 is seen as beyond f_stop, not wrapped.
  always_comb begin
    dwell_last = (dwell_q == 16'd0) ? 16'd0 : (dwell_q - 16'd1);
    boundary   = (cnt_q == dwell_last);
    up_sum     = {1'b0, state_freq_q} + {1'b0, f_step_q};
    up_ok      = (up_sum <= {1'b0, f_stop_q});
    dn_diff    = state_freq_q - f_step_q;
    dn_ok      = (state_freq_q >= f_step_q) && (dn_diff >= f_start_q);
  end

  always_comb begin
    logic reload_ap;
    reload_ap     = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    mode_d        = mode_q;
    f_start_d     = f_start_q;
    f_stop_d      = f_stop_q;
    f_step_d      = f_step_q;
    dwell_d       = dwell_q;
    en_d          = en_q;
    state_freq_d  = state_freq_q;
    state_amp_d   = state_amp_q;
    state_phase_d = state_phase_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    wrap_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          mode_d        = mode;
          f_start_d     = f_start;
          f_stop_d      = f_stop;
          f_step_d      = f_step;
          dwell_d       = dwell;
          state_freq_d  = f_start;
          state_amp_d   = amp_in;
          state_phase_d = phase_in;
          en_d          = 1'b1;
          busy_d        = 1'b1;
          cnt_d         = 16'd0;
          dir_d         = DIR_UP;
          state_d       = ST_RUN;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = 16'd0;
        end else if (!boundary) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d     = 16'd0;
          reload_ap = 1'b1;
          if (dir_q == DIR_UP) begin
            if (up_ok) begin
              state_freq_d = up_sum[13:0];
            end else begin
              case (mode_q)
                MODE_REPEAT: begin
                  state_freq_d = f_start_q;
                  wrap_d       = 1'b1;
                end
                MODE_UPDOWN: begin
                  dir_d = DIR_DOWN;
                  if (dn_ok) state_freq_d = dn_diff;
                end
                default: begin
                  state_d   = ST_IDLE;
                  en_d      = 1'b0;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  reload_ap = 1'b0;
                end
              endcase
            end
          end else begin
            // Bottom reversal of an up-down sweep: climb back up and flag the new period.
            if (!dn_ok) begin
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
              if (up_ok) state_freq_d = up_sum[13:0];
            end else begin
              state_freq_d = dn_diff;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reload_ap) begin
      state_amp_d   = amp_in;
      state_phase_d = phase_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      dir_q         <= DIR_UP;
      mode_q        <= 2'd0;
      f_start_q     <= 14'd0;
      f_stop_q      <= 14'd0;
      f_step_q      <= 14'd0;
      dwell_q       <= 16'd0;
      en_q          <= 1'b0;
      state_freq_q  <= 14'd0;
      state_amp_q   <= 8'd0;
      state_phase_q <= 8'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      mode_q        <= mode_d;
      f_start_q     <= f_start_d;
      f_stop_q      <= f_stop_d;
      f_step_q      <= f_step_d;
      dwell_q       <= dwell_d;
      en_q          <= en_d;
      state_freq_q  <= state_freq_d;
      state_amp_q   <= state_amp_d;
      state_phase_q <= state_phase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wrap_q        <= wrap_d;
    end
  end

  assign en          = en_q;
  assign state_freq  = state_freq_q;
  assign state_amp   = state_amp_q;
  assign state_phase = state_phase_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Bench for awg_sweep_ctrl: directed scenarios with literal expectations, then
// randomized sweeps, all compared every cycle against a behavioural sweep model.
module tb_awg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [13:0] f_start;
  logic [13:0] f_stop;
  logic [13:0] f_step;
  logic [15:0] dwell;
  logic [7:0]  amp_in;
  logic [7:0]  phase_in;
  logic        en;
  logic [13:0] state_freq;
  logic [7:0]  state_amp;
  logic [7:0]  state_phase;
  logic        busy;
  logic        done;
  logic        wrap;

  int checks = 0;
  int errors = 0;

  // Model of what the generator should see, in plain integer terms.
  bit m_run, m_up, m_en, m_busy, m_done, m_wrap;
  int m_freq, m_amp, m_phase, m_left;
  int s_mode, s_start, s_stop, s_step, s_dwell_eff;

  awg_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .amp_in(amp_in), .phase_in(phase_in), .en(en), .state_freq(state_freq),
    .state_amp(state_amp), .state_phase(state_phase), .busy(busy),
    .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic m_reset();
    m_run = 0; m_up = 1; m_en = 0; m_busy = 0; m_done = 0; m_wrap = 0;
    m_freq = 0; m_amp = 0; m_phase = 0; m_left = 0;
    s_mode = 0; s_start = 0; s_stop = 0; s_step = 0; s_dwell_eff = 1;
  endtask

  // Move to the next frequency point of the sweep.
  task automatic m_next_point();
    if (m_up) begin
      if (m_freq + s_step <= s_stop) m_freq = m_freq + s_step;
      else if (s_mode == 1) begin
        m_freq = s_start; m_wrap = 1;
      end else if (s_mode == 2) begin
        m_up = 0;
        if (m_freq - s_step >= s_start) m_freq = m_freq - s_step;
      end else begin
        m_run = 0; m_en = 0; m_busy = 0; m_done = 1;
      end
    end else begin
      if (m_freq - s_step < s_start) begin
        m_up = 1; m_wrap = 1;
        if (m_freq + s_step <= s_stop) m_freq = m_freq + s_step;
      end else begin
        m_freq = m_freq - s_step;
      end
    end
    if (m_run) begin
      m_amp = int'(amp_in); m_phase = int'(phase_in);
    end
  endtask

  task automatic m_edge();
    m_done = 0; m_wrap = 0;
    if (!m_run) begin
      if (start && !stop) begin
        s_mode = (mode == 2'd3) ? 0 : int'(mode);
        s_start = int'(f_start); s_stop = int'(f_stop); s_step = int'(f_step);
        s_dwell_eff = (dwell == 16'd0) ? 1 : int'(dwell);
        m_freq = s_start; m_amp = int'(amp_in); m_phase = int'(phase_in);
        m_en = 1; m_busy = 1; m_up = 1; m_run = 1; m_left = s_dwell_eff;
      end
    end else if (stop) begin
      m_run = 0; m_en = 0; m_busy = 0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left = s_dwell_eff;
        m_next_point();
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("en", int'(en), int'(m_en));
      checkOutput("busy", int'(busy), int'(m_busy));
      checkOutput("done", int'(done), int'(m_done));
      checkOutput("wrap", int'(wrap), int'(m_wrap));
      checkOutput("state_freq", int'(state_freq), m_freq);
      checkOutput("state_amp", int'(state_amp), m_amp);
      checkOutput("state_phase", int'(state_phase), m_phase);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program a configuration and hold start for exactly one edge.
  task automatic applyStimulus(input int md, input int fs, input int fe, input int fst,
                               input int dw, input int amp, input int ph);
    mode = 2'(md); f_start = 14'(fs); f_stop = 14'(fe); f_step = 14'(fst);
    dwell = 16'(dw); amp_in = 8'(amp); phase_in = 8'(ph);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stopSweep();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic randomConfig();
    case ($urandom_range(0, 3))
      0: begin
        f_start = 14'($urandom_range(16000, 16383));
        f_stop  = 14'd16383;
        f_step  = 14'($urandom_range(50, 400));
      end
      1: begin
        f_start = 14'($urandom_range(0, 50));
        f_stop  = 14'($urandom_range(100, 600));
        f_step  = 14'($urandom_range(60, 700));
      end
      default: begin
        f_start = 14'($urandom_range(0, 600));
        f_stop  = 14'($urandom_range(0, 1000));
        f_step  = 14'($urandom_range(0, 300));
      end
    endcase
    if (f_step == 14'd0 && f_start > f_stop) f_step = 14'd1;
    mode  = 2'($urandom_range(0, 3));
    dwell = 16'($urandom_range(0, 6));
  endtask

  int seq_ud [8] = '{100, 200, 300, 200, 100, 200, 300, 200};
  int seq_rp [6] = '{100, 200, 300, 100, 200, 300};

  initial begin
    int exp_f, wraps, bad;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    f_start = 14'd0; f_stop = 14'd0; f_step = 14'd0; dwell = 16'd0;
    amp_in = 8'd0; phase_in = 8'd0;
    tick(); tick();
    checkOutput("reset_en", int'(en), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_freq", int'(state_freq), 0);
    checkOutput("reset_amp", int'(state_amp), 0);
    rst = 1'b0;
    tick();

    $display("[TB] single sweep 100..300 step 100 dwell 4");
    applyStimulus(0, 100, 300, 100, 4, 10, 20);
    for (int j = 0; j <= 12; j++) begin
      exp_f = (j < 4) ? 100 : (j < 8) ? 200 : 300;
      checkOutput("single_freq", int'(state_freq), exp_f);
      checkOutput("single_en", int'(en), (j < 12) ? 1 : 0);
      checkOutput("single_done", int'(done), (j == 12) ? 1 : 0);
      if (j < 12) tick();
    end
    applyStimulus(0, 50, 50, 10, 2, 1, 1);
    checkOutput("b2b_en", int'(en), 1);
    checkOutput("b2b_freq", int'(state_freq), 50);
    stopSweep();

    $display("[TB] deferred amplitude and stop on a step edge");
    applyStimulus(1, 100, 300, 100, 4, 10, 0);
    tick();
    amp_in = 8'd20;
    tick();
    checkOutput("amp_hold_mid_dwell", int'(state_amp), 10);
    tick(); tick();
    checkOutput("amp_at_step", int'(state_amp), 20);
    checkOutput("freq_at_step", int'(state_freq), 200);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_step_en", int'(en), 0);
    checkOutput("stop_step_done", int'(done), 0);
    checkOutput("stop_step_freq", int'(state_freq), 200);
    tick();

    $display("[TB] up-down sweep");
    applyStimulus(2, 100, 300, 100, 2, 0, 0);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 2; c++) begin
        checkOutput("updown_freq", int'(state_freq), seq_ud[p]);
        checkOutput("updown_wrap", int'(wrap), (p == 5 && c == 0) ? 1 : 0);
        tick();
      end
    end
    stopSweep();

    $display("[TB] repeat sweep dwell 1");
    applyStimulus(1, 100, 300, 100, 1, 0, 0);
    for (int p = 0; p < 6; p++) begin
      checkOutput("repeat_freq", int'(state_freq), seq_rp[p]);
      checkOutput("repeat_wrap", int'(wrap), (p == 3) ? 1 : 0);
      tick();
    end
    stopSweep();

    $display("[TB] dwell 0, single point");
    applyStimulus(0, 500, 400, 50, 0, 0, 0);
    checkOutput("point_freq", int'(state_freq), 500);
    checkOutput("point_en", int'(en), 1);
    tick();
    checkOutput("point_done", int'(done), 1);
    checkOutput("point_en_fall", int'(en), 0);
    tick();

    $display("[TB] zero step tone");
    applyStimulus(1, 100, 300, 0, 3, 0, 0);
    wraps = 0; bad = 0;
    for (int j = 0; j < 1000; j++) begin
      if (wrap) wraps++;
      if (state_freq != 14'd100) bad++;
      tick();
    end
    checkOutput("tone_wraps", wraps, 0);
    checkOutput("tone_freq_changes", bad, 0);
    stopSweep();

    $display("[TB] reset mid-sweep");
    applyStimulus(0, 100, 300, 100, 4, 9, 9);
    tick(); tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_en", int'(en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_freq", int'(state_freq), 0);
    checkOutput("rst_amp", int'(state_amp), 0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(0, 7, 20, 5, 2, 3, 4);
    checkOutput("post_rst_freq", int'(state_freq), 7);
    tick(); tick();
    checkOutput("post_rst_step", int'(state_freq), 12);
    stopSweep();

    $display("[TB] randomized sweeps");
    for (int s = 0; s < 60; s++) begin
      randomConfig();
      amp_in = 8'($urandom); phase_in = 8'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = $urandom_range(5, 150); n > 0; n--) begin
        amp_in = 8'($urandom); phase_in = 8'($urandom);
        if ($urandom_range(0, 9) == 0) begin
          randomConfig();
          start = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
        stop = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 199) == 0) begin
          rst = 1'b1;
          #2;
          rst = 1'b0;
        end
        tick();
      end
      start = 1'b0;
      stopSweep();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
